// File: rtl/ic_tester_pkg.sv
// Shared definitions for the logic-gate IC test sequencer: family/op codes,
// FSM states and the golden gate model.
package ic_tester_pkg;

  localparam logic [2:0] FAM_NOT = 3'b000;
  localparam logic [2:0] FAM_IN2 = 3'b001;
  localparam logic [2:0] FAM_IN3 = 3'b010;
  localparam logic [2:0] FAM_IN4 = 3'b011;
  localparam logic [2:0] FAM_IN8 = 3'b100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_NOR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_APPLY,
    ST_SAMPLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Zero marks an invalid family code.
  function automatic logic [3:0] num_inputs(input logic [2:0] family);
    case (family)
      FAM_NOT: return 4'd1;
      FAM_IN2: return 4'd2;
      FAM_IN3: return 4'd3;
      FAM_IN4: return 4'd4;
      FAM_IN8: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic family_valid(input logic [2:0] family);
    return num_inputs(family) != 4'd0;
  endfunction

  // Mask of the used stimulus bits; also equals the last vector V-1.
  function automatic logic [7:0] vec_mask(input logic [2:0] family);
    logic [8:0] full;
    full = (9'd1 << num_inputs(family)) - 9'd1;
    return full[7:0];
  endfunction

  function automatic logic golden(input logic [2:0] family, input logic [1:0] op,
                                  input logic [7:0] stim);
    logic [7:0] m;
    logic       red;
    m = vec_mask(family);
    if (family == FAM_NOT) return ~stim[0];
    if (op == OP_AND || op == OP_NAND) red = &(stim | ~m);
    else                               red = |(stim & m);
    return (op == OP_NAND || op == OP_NOR) ? ~red : red;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous DUT gate output.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ic_test_sequencer.sv
// Runs one exhaustive functional test of a logic-gate IC and reports
// pass/fail with the first failing input vector.
//
// state  | meaning
// IDLE   | waiting for start; results held
// SETUP  | validate latched family, reset stimulus
// APPLY  | hold stim for SETTLE_CYCLES clocks
// SAMPLE | capture synchronized DUT response
// CHECK  | compare against golden, advance or finish
// DONE   | one-cycle done pulse
module ic_test_sequencer
  import ic_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] ic_family,
  input  logic [1:0] gate_op,
  input  logic       dut_out,
  output logic [2:0] select,
  output logic [7:0] stim,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       bad_family,
  output logic [7:0] fail_vector
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_next;
  logic [1:0] op_q;
  logic [7:0] settle_cnt;
  logic       dut_sync;
  logic       resp;
  logic       match;
  logic       last_vec;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (dut_out),
    .q     (dut_sync)
  );

  assign match    = (resp == golden(select, op_q, stim));
  assign last_vec = (stim == vec_mask(select));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        busy       = 1'b1;
        state_next = family_valid(select) ? ST_APPLY : ST_DONE;
      end
      ST_APPLY: begin
        busy = 1'b1;
        if (settle_cnt == SETTLE_LAST) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        busy       = 1'b1;
        state_next = ST_CHECK;
      end
      ST_CHECK: begin
        busy       = 1'b1;
        state_next = (!match || last_vec) ? ST_DONE : ST_APPLY;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      select      <= 3'b000;
      op_q        <= 2'b00;
      stim        <= 8'h00;
      settle_cnt  <= 8'h00;
      resp        <= 1'b0;
      pass        <= 1'b0;
      bad_family  <= 1'b0;
      fail_vector <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            select      <= ic_family;
            op_q        <= gate_op;
            pass        <= 1'b0;
            bad_family  <= 1'b0;
            fail_vector <= 8'h00;
          end
        end
        ST_SETUP: begin
          if (!family_valid(select)) begin
            bad_family <= 1'b1;
            pass       <= 1'b0;
          end else begin
            stim       <= 8'h00;
            settle_cnt <= 8'h00;
          end
        end
        ST_APPLY:  settle_cnt <= settle_cnt + 8'd1;
        ST_SAMPLE: resp <= dut_sync;
        ST_CHECK: begin
          if (!match) begin
            fail_vector <= stim;
            pass        <= 1'b0;
          end else if (last_vec) begin
            pass <= 1'b1;
          end else begin
            stim       <= stim + 8'd1;
            settle_cnt <= 8'h00;
          end
        end
        ST_DONE: stim <= 8'h00;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ic_test_sequencer.sv
// Directed, table-driven bench for ic_test_sequencer with a behavioural IC model.
module tb_ic_test_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] ic_family;
  logic [1:0] gate_op;
  logic       dut_out;
  logic [2:0] select;
  logic [7:0] stim;
  logic       busy;
  logic       done;
  logic       pass;
  logic       bad_family;
  logic [7:0] fail_vector;

  int checks = 0;
  int errors = 0;

  // IC model configuration: 0 correct, 1 stuck at 1, 2 wrong only at 0xFF, 3 stuck at 0
  logic [2:0] m_fam = 3'b000;
  logic [1:0] m_op  = 2'b00;
  int         mode  = 0;
  logic [7:0] m_mask;
  logic       m_ideal;

  ic_test_sequencer #(.SETTLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ic_family   (ic_family),
    .gate_op     (gate_op),
    .dut_out     (dut_out),
    .select      (select),
    .stim        (stim),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .bad_family  (bad_family),
    .fail_vector (fail_vector)
  );

  always #5 clk = ~clk;

  always_comb begin
    m_mask  = 8'hff;
    m_ideal = 1'b0;
    dut_out = 1'b0;
    case (m_fam)
      3'd0:    m_mask = 8'h01;
      3'd1:    m_mask = 8'h03;
      3'd2:    m_mask = 8'h07;
      3'd3:    m_mask = 8'h0f;
      default: m_mask = 8'hff;
    endcase
    if (m_fam == 3'd0) m_ideal = !stim[0];
    else begin
      case (m_op)
        2'd0: m_ideal = ((stim & m_mask) == m_mask);
        2'd1: m_ideal = ((stim & m_mask) != 8'h00);
        2'd2: m_ideal = ((stim & m_mask) != m_mask);
        2'd3: m_ideal = ((stim & m_mask) == 8'h00);
        default: m_ideal = 1'b0;
      endcase
    end
    case (mode)
      0:       dut_out = m_ideal;
      1:       dut_out = 1'b1;
      2:       dut_out = (stim == 8'hff) ? !m_ideal : m_ideal;
      default: dut_out = 1'b0;
    endcase
  end

  typedef struct {
    logic [2:0] fam;
    logic [1:0] op;
    int         mode;
    bit         poke;
    int         exp_cyc;
    logic       exp_pass;
    logic       exp_bad;
    logic [7:0] exp_fv;
    logic [7:0] exp_max;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int         cyc;
    int         busy_n;
    int         step_err;
    logic [7:0] smax;
    logic [7:0] sprev;
    bit         got;
    @(negedge clk);
    ic_family = v.fam;
    gate_op   = v.op;
    m_fam     = v.fam;
    m_op      = v.op;
    mode      = v.mode;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    ic_family = ~v.fam;
    gate_op   = ~v.op;
    cyc = 1; got = 0; busy_n = 0; step_err = 0; smax = 0; sprev = 0;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      if (v.poke) begin
        start     = (cyc == 10);
        ic_family = (cyc == 10) ? 3'b000 : ~v.fam;
      end
      if (cyc == 1) chk("select_early", {29'd0, select}, {29'd0, v.fam});
      if (busy) busy_n++;
      if (busy && stim != sprev) begin
        if (32'(stim) != 32'(sprev) + 1) step_err++;
        sprev = stim;
      end
      if (stim > smax) smax = stim;
      if (done) got = 1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("done_cycle", cyc, v.exp_cyc);
      chk("pass", {31'd0, pass}, {31'd0, v.exp_pass});
      chk("bad_family", {31'd0, bad_family}, {31'd0, v.exp_bad});
      chk("fail_vector", {24'd0, fail_vector}, {24'd0, v.exp_fv});
      chk("select_done", {29'd0, select}, {29'd0, v.fam});
      chk("stim_max", {24'd0, smax}, {24'd0, v.exp_max});
      chk("stim_step", step_err, 0);
      chk("busy_cycles", busy_n, v.exp_cyc - 1);
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("stim_idle", {24'd0, stim}, 32'd0);
      chk("pass_hold", {31'd0, pass}, {31'd0, v.exp_pass});
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_select"}, {29'd0, select}, 32'd0);
    chk({tag, "_stim"}, {24'd0, stim}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_bad"}, {31'd0, bad_family}, 32'd0);
    chk({tag, "_fv"}, {24'd0, fail_vector}, 32'd0);
  endtask

  initial begin
    int  seen;
    //          fam     op     mode poke cyc   pass  bad   fv     max
    tbl[0] = '{3'b001, 2'b10, 0, 0, 26,   1'b1, 1'b0, 8'h00, 8'h03};
    tbl[1] = '{3'b000, 2'b00, 0, 0, 14,   1'b1, 1'b0, 8'h00, 8'h01};
    tbl[2] = '{3'b000, 2'b00, 1, 0, 14,   1'b0, 1'b0, 8'h01, 8'h01};
    tbl[3] = '{3'b100, 2'b00, 2, 0, 1538, 1'b0, 1'b0, 8'hff, 8'hff};
    tbl[4] = '{3'b110, 2'b01, 0, 0, 2,    1'b0, 1'b1, 8'h00, 8'h00};
    tbl[5] = '{3'b011, 2'b01, 0, 1, 98,   1'b1, 1'b0, 8'h00, 8'h0f};
    tbl[6] = '{3'b010, 2'b11, 1, 0, 14,   1'b0, 1'b0, 8'h01, 8'h01};
    tbl[7] = '{3'b011, 2'b00, 3, 0, 98,   1'b0, 1'b0, 8'h0f, 8'h0f};
    tbl[8] = '{3'b111, 2'b00, 0, 0, 2,    1'b0, 1'b1, 8'h00, 8'h00};

    reset = 1'b1; start = 1'b0; ic_family = 3'b000; gate_op = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Reset in the middle of a 4-input test
    @(negedge clk);
    ic_family = 3'b011; gate_op = 2'b01; m_fam = 3'b011; m_op = 2'b01; mode = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c < 20; c++) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs("midrst");
    seen = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("no_activity_after_reset", seen, 0);

    run_vec(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
